// File: rtl/btn_instr_issue_pkg.sv
// Shared types and constants for the button-driven instruction issue front end.
// The instruction word layout is {op, x, y, z}, and each field is 2 bits wide.
package btn_instr_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] x;
    logic [1:0] y;
    logic [1:0] z;
  } instr_t;

  localparam logic [1:0] LDL = 2'b00;
  localparam logic [1:0] LDH = 2'b01;
  localparam logic [1:0] ADD = 2'b10;
  localparam logic [1:0] SUB = 2'b11;

endpackage

// File: rtl/btn_instr_issue_debounce.sv
// Two-flop synchroniser followed by a counting debouncer.
// The level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_meta;
  logic             btn_s;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      cnt      <= '0;
      level_o  <= 1'b0;
      rise_o   <= 1'b0;
      fall_o   <= 1'b0;
    end else begin
      btn_meta <= raw_i;
      btn_s    <= btn_meta;
      rise_o   <= 1'b0;
      fall_o   <= 1'b0;
      // Any sample agreeing with the current level restarts the window.
      if (btn_s != level_o) begin
        if (cnt == CNT_LAST) begin
          level_o <= ~level_o;
          cnt     <= '0;
          rise_o  <= ~level_o;
          fall_o  <= level_o;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/btn_instr_issue.sv
// Issues one switch-captured instruction per debounced button press over a valid/ready link.
// A press that arrives while a transfer is pending is absorbed, not queued.
module btn_instr_issue
  import btn_instr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int INSTR_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_raw,
  input  logic [INSTR_W-1:0] sw_raw,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic               busy_o,
  output logic [7:0]         issue_cnt_o
);

  logic [INSTR_W-1:0] sw_meta;
  logic [INSTR_W-1:0] sw_s;
  logic               db_level;
  logic               db_rise;
  logic               db_fall;
  state_t             state;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (btn_raw),
    .level_o(db_level),
    .rise_o (db_rise),
    .fall_o (db_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_s    <= '0;
    end else begin
      sw_meta <= sw_raw;
      sw_s    <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      instr_o       <= '0;
      instr_valid_o <= 1'b0;
      issue_cnt_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (db_rise) begin
            instr_o       <= sw_s;
            instr_valid_o <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready_i) begin
            instr_valid_o <= 1'b0;
            issue_cnt_o   <= issue_cnt_o + 8'd1;
            state         <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          // A release during a stalled transfer lets us leave without waiting for a new fall.
          if (!db_level || db_fall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state != IDLE);

endmodule
